// File: rtl/debounce_bank.sv
// Multi-channel button/switch debouncer: 2-flop synchroniser, shared prescaled
// sample tick, per-channel stable counter and optional auto-repeat FSM.
module debounce_bank #(
    parameter int              N_CH         = 9,
    parameter int              TICK_DIV     = 1000,
    parameter int              STABLE_CNT   = 6,
    parameter int              REPEAT_DELAY = 500,
    parameter int              REPEAT_RATE  = 100,
    parameter logic [N_CH-1:0] REPEAT_MASK  = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] rpt,
    output logic            tick
);

    localparam int PRE_W   = $clog2(TICK_DIV);
    localparam int SCNT_W  = $clog2(STABLE_CNT);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        RS_IDLE   = 2'd0,
        RS_DELAY  = 2'd1,
        RS_REPEAT = 2'd2
    } rpt_state_e;

    logic [N_CH-1:0]  sync1_q;
    logic [N_CH-1:0]  sync2_q;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pre_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
        end
    end

    assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

    always_comb begin
        pre_d = pre_q + 1'b1;
        if (tick) pre_d = '0;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic              lvl_q;
        logic              lvl_d;
        logic [SCNT_W-1:0] scnt_q;
        logic [SCNT_W-1:0] scnt_d;
        logic              rise_q;
        logic              rise_d;
        logic              fall_q;
        logic              fall_d;
        logic              rpt_q;
        logic [RPT_W-1:0]  rcnt_q;
        rpt_state_e        state_q;

        // A level change is accepted on the tick that completes STABLE_CNT disagreeing samples.
        always_comb begin
            lvl_d  = lvl_q;
            scnt_d = scnt_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (tick) begin
                if (sync2_q[i] == lvl_q) begin
                    scnt_d = '0;
                end else if (scnt_q == SCNT_W'(STABLE_CNT - 1)) begin
                    lvl_d  = ~lvl_q;
                    scnt_d = '0;
                    rise_d = ~lvl_q;
                    fall_d = lvl_q;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                lvl_q   <= 1'b0;
                scnt_q  <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                rpt_q   <= 1'b0;
                rcnt_q  <= '0;
                state_q <= RS_IDLE;
            end else begin
                lvl_q  <= lvl_d;
                scnt_q <= scnt_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
                rpt_q  <= 1'b0;
                case (state_q)
                    RS_IDLE: begin
                        if (rise_d) begin
                            rpt_q  <= 1'b1;
                            rcnt_q <= '0;
                            if (REPEAT_MASK[i]) state_q <= RS_DELAY;
                        end
                    end
                    // A release wins over a repeat pulse falling due on the same tick.
                    RS_DELAY: begin
                        if (fall_d) begin
                            state_q <= RS_IDLE;
                        end else if (tick) begin
                            if (rcnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
                                rpt_q   <= 1'b1;
                                rcnt_q  <= '0;
                                state_q <= RS_REPEAT;
                            end else begin
                                rcnt_q <= rcnt_q + 1'b1;
                            end
                        end
                    end
                    RS_REPEAT: begin
                        if (fall_d) begin
                            state_q <= RS_IDLE;
                        end else if (tick) begin
                            if (rcnt_q == RPT_W'(REPEAT_RATE - 1)) begin
                                rpt_q  <= 1'b1;
                                rcnt_q <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= RS_IDLE;
                endcase
            end
        end

        assign level[i] = lvl_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
        assign rpt[i]   = rpt_q;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: pulse events are captured with their cycle stamp and
// checked against expected events queued by each scenario.
module tb_debounce_bank;

    localparam int N = 4;
    localparam int W = 3 * N;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] din;
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] rpt;
    logic         tick;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [W-1:0] obs_q[$];
    int           obs_cyc_q[$];

    debounce_bank #(
        .N_CH        (N),
        .TICK_DIV    (4),
        .STABLE_CNT  (3),
        .REPEAT_DELAY(5),
        .REPEAT_RATE (2),
        .REPEAT_MASK (4'b0001)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .din  (din),
        .level(level),
        .rise (rise),
        .fall (fall),
        .rpt  (rpt),
        .tick (tick)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Event monitor: every cycle carrying a pulse becomes one {rise,fall,rpt} word.
    always @(negedge clk) begin
        if (!reset && ((rise | fall | rpt) != '0)) begin
            obs_q.push_back({rise, fall, rpt});
            obs_cyc_q.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_obs(input int budget);
        int n;
        n = 0;
        while (obs_q.size() == 0 && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int c, tick_bad, lvl_bad;
        reset = 1'b1;
        din   = '0;
        steps(3);
        tests_run++;
        if ({level, rise, fall, rpt, tick} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", {level, rise, fall, rpt, tick});
        end
        reset = 1'b0;
        c = cyc;
        clear_obs();
        tick_bad = 0;
        lvl_bad  = 0;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (tick !== (((cyc - c) % 4) == 3)) tick_bad++;
            if (level !== '0) lvl_bad++;
        end
        tests_run++;
        if (tick_bad != 0) begin
            tests_failed++;
            $display("FAIL tick_pattern: %0d bad cycles, expected 0", tick_bad);
        end
        tests_run++;
        if (lvl_bad != 0) begin
            tests_failed++;
            $display("FAIL idle_level: %0d cycles with level!=0, expected 0", lvl_bad);
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL idle_pulses: got %0d events expected 0", obs_q.size());
        end
    endtask

    task automatic test_step();
        logic [W-1:0] e, o;
        int start, oc;
        clear_obs();
        start  = cyc;
        din[1] = 1'b1;
        exp_q.push_back({4'b0010, 4'b0000, 4'b0010});
        wait_obs(40);
        e = exp_q.pop_front();
        tests_run++;
        if (obs_q.size() == 0) begin
            tests_failed++;
            $display("FAIL step_rise: got no event expected %h", e);
        end else begin
            o  = obs_q.pop_front();
            oc = obs_cyc_q.pop_front();
            if (o !== e) begin
                tests_failed++;
                $display("FAIL step_rise: got %h expected %h", o, e);
            end
            tests_run++;
            if (oc - start < 11 || oc - start > 15) begin
                tests_failed++;
                $display("FAIL step_latency: got %0d expected 11..15", oc - start);
            end
        end
        steps(12);
        tests_run++;
        if (obs_q.size() != 0 || level !== 4'b0010) begin
            tests_failed++;
            $display("FAIL step_hold: got %0d extra events level %b expected 0 events level 0010",
                     obs_q.size(), level);
        end
        clear_obs();
        din[1] = 1'b0;
        exp_q.push_back({4'b0000, 4'b0010, 4'b0000});
        wait_obs(40);
        e = exp_q.pop_front();
        tests_run++;
        if (obs_q.size() == 0) begin
            tests_failed++;
            $display("FAIL step_fall: got no event expected %h", e);
        end else begin
            o = obs_q.pop_front();
            void'(obs_cyc_q.pop_front());
            if (o !== e) begin
                tests_failed++;
                $display("FAIL step_fall: got %h expected %h", o, e);
            end
        end
        steps(20);
        tests_run++;
        if (obs_q.size() != 0 || level !== 4'b0000) begin
            tests_failed++;
            $display("FAIL step_quiet: got %0d events level %b expected 0 events level 0000",
                     obs_q.size(), level);
        end
    endtask

    task automatic test_glitch();
        logic [W-1:0] e, o;
        clear_obs();
        din[2] = 1'b1;
        steps(6);
        din[2] = 1'b0;
        steps(10);
        for (int k = 0; k < 100; k++) begin
            din[2] = ((k / 3) % 2) == 0;
            step();
        end
        din[2] = 1'b0;
        steps(20);
        tests_run++;
        if (obs_q.size() != 0 || level[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_reject: got %0d events level2 %b expected 0 events level2 0",
                     obs_q.size(), level[2]);
        end
        clear_obs();
        din[2] = 1'b1;
        exp_q.push_back({4'b0100, 4'b0000, 4'b0100});
        steps(30);
        din[2] = 1'b0;
        exp_q.push_back({4'b0000, 4'b0100, 4'b0000});
        steps(30);
        tests_run++;
        if (obs_q.size() != 2) begin
            tests_failed++;
            $display("FAIL glitch_clean_count: got %0d events expected 2", obs_q.size());
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL glitch_clean_event: got no event expected %h", e);
            end else begin
                o = obs_q.pop_front();
                void'(obs_cyc_q.pop_front());
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL glitch_clean_event: got %h expected %h", o, e);
                end
            end
        end
    endtask

    task automatic test_repeat();
        logic [W-1:0] e, o;
        int t_r, ec, oc;
        clear_obs();
        din[0] = 1'b1;
        wait_obs(40);
        tests_run++;
        if (obs_q.size() == 0) begin
            tests_failed++;
            $display("FAIL repeat_press: got no event expected %h", {4'b0001, 4'b0000, 4'b0001});
        end else begin
            o   = obs_q.pop_front();
            t_r = obs_cyc_q.pop_front();
            if (o !== {4'b0001, 4'b0000, 4'b0001}) begin
                tests_failed++;
                $display("FAIL repeat_press: got %h expected %h", o, {4'b0001, 4'b0000, 4'b0001});
            end
            // First repeat after 5 ticks, then every 2 ticks; the release lands
            // its fall on a tick where a repeat would also be due.
            for (int j = 0; j < 7; j++) begin
                exp_q.push_back({4'b0000, 4'b0000, 4'b0001});
                exp_cyc_q.push_back(t_r + 20 + 8 * j);
            end
            exp_q.push_back({4'b0000, 4'b0001, 4'b0000});
            exp_cyc_q.push_back(t_r + 76);
            while (cyc < t_r + 65) step();
            din[0] = 1'b0;
            while (cyc < t_r + 100) step();
            while (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                tests_run++;
                if (obs_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL repeat_event: got no event expected %h at +%0d", e, ec - t_r);
                end else begin
                    o  = obs_q.pop_front();
                    oc = obs_cyc_q.pop_front();
                    if (o !== e || oc != ec) begin
                        tests_failed++;
                        $display("FAIL repeat_event: got %h at +%0d expected %h at +%0d",
                                 o, oc - t_r, e, ec - t_r);
                    end
                end
            end
            tests_run++;
            if (obs_q.size() != 0) begin
                tests_failed++;
                $display("FAIL repeat_after_fall: got %0d extra events expected 0", obs_q.size());
            end
        end
    endtask

    task automatic test_all_and_reset();
        logic [W-1:0] e, o;
        clear_obs();
        din = 4'b1111;
        exp_q.push_back({4'b1111, 4'b0000, 4'b1111});
        wait_obs(40);
        e = exp_q.pop_front();
        tests_run++;
        if (obs_q.size() == 0) begin
            tests_failed++;
            $display("FAIL all_rise: got no event expected %h", e);
        end else begin
            o = obs_q.pop_front();
            void'(obs_cyc_q.pop_front());
            if (o !== e) begin
                tests_failed++;
                $display("FAIL all_rise: got %h expected %h", o, e);
            end
        end
        din = 4'b0000;
        steps(6);
        reset = 1'b1;
        step();
        tests_run++;
        if ({level, rise, fall, rpt, tick} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got %h expected 0", {level, rise, fall, rpt, tick});
        end
        reset = 1'b0;
        clear_obs();
        steps(40);
        tests_run++;
        if (obs_q.size() != 0 || level !== 4'b0000) begin
            tests_failed++;
            $display("FAIL post_reset_quiet: got %0d events level %b expected 0 events level 0000",
                     obs_q.size(), level);
        end
    endtask

    task automatic test_held_through_reset();
        logic [W-1:0] e, o;
        int start, oc;
        din   = 4'b1000;
        reset = 1'b1;
        steps(3);
        reset = 1'b0;
        start = cyc;
        clear_obs();
        exp_q.push_back({4'b1000, 4'b0000, 4'b1000});
        wait_obs(40);
        e = exp_q.pop_front();
        tests_run++;
        if (obs_q.size() == 0) begin
            tests_failed++;
            $display("FAIL held_rise: got no event expected %h", e);
        end else begin
            o  = obs_q.pop_front();
            oc = obs_cyc_q.pop_front();
            if (o !== e) begin
                tests_failed++;
                $display("FAIL held_rise: got %h expected %h", o, e);
            end
            tests_run++;
            if (oc - start < 11 || oc - start > 15) begin
                tests_failed++;
                $display("FAIL held_latency: got %0d expected 11..15", oc - start);
            end
        end
        steps(30);
        tests_run++;
        if (obs_q.size() != 0 || level !== 4'b1000) begin
            tests_failed++;
            $display("FAIL held_stay: got %0d events level %b expected 0 events level 1000",
                     obs_q.size(), level);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        din   = '0;
        test_reset();
        test_step();
        test_glitch();
        test_repeat();
        test_all_and_reset();
        test_held_through_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
